ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage op, funct and register operands. Owns the architectural HI/LO registers.
- Drives a stall back into the upstream pipeline registers while an operation iterates.
- Supplies MFHI/MFLO read data to the EX result mux.

Parameters:
- XLEN, 32, operand/HI/LO width. Only 32 is supported.
- ITER, 32, iteration cycles per mult/div. Must equal XLEN.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ex_op  in  6  opcode of the instruction in EX
- ex_funct  in  6  funct field of the instruction in EX
- ex_reg_data1  in  32  rs operand (already forwarded)
- ex_reg_data2  in  32  rt operand (already forwarded)
- md_stall  out  1  hold IF/ID and ID/EX, bubble EX/MEM
- md_result  out  32  HI for MFHI, LO for MFLO, else 0
- md_hi  out  32  current HI register
- md_lo  out  32  current LO register

Behaviour:
- Decode, valid only when ex_op==0:
  - funct 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU are "start".
  - 0x10 MFHI, 0x12 MFLO are reads.
  - 0x11 MTHI, 0x13 MTLO are writes.
- Reset (clock edge with reset=1): state=IDLE, HI=LO=0, counter=0, operand/accumulator regs=0. md_stall=0 while reset high. Reset mid-operation aborts it; HI/LO end at 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE & start & divisor!=0 (or a mult): latch |rs|, |rt| (magnitudes for signed ops) and the result sign(s); counter=0; go to BUSY. md_stall=1 this cycle.
  - IDLE & DIV/DIVU & rt==0: go to DONE. HI/LO unchanged. md_stall=1 this cycle.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; md_stall=1. When counter==ITER-1: write HI/LO with the sign-corrected result, go to DONE. Otherwise counter+1.
  - DONE: md_stall=0 so the instruction leaves EX; start is ignored; go to IDLE next cycle.
- Latency: a mult/div occupies EX for 1+ITER+1 = 34 cycles, with md_stall high for 33 of them.
- Sign rules:
  - MULT: 64-bit product negated if the operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MTHI/MTLO in IDLE write HI/LO at the clock edge (no stall).
- MFHI/MFLO: md_result is combinational from the HI/LO registers.
  - A mult/div followed immediately by MFHI reads the new value, since HI/LO are written at BUSY->DONE before the MF enters EX.
- Start is decoded only in IDLE, so a stalled instruction held in EX is never re-launched.
- md_hi/md_lo always reflect the registers.

Optional Feature:
- Macro MULDIV_MADD_EN.
- When defined: ex_op==0x1C with funct 0x00 MADD, 0x01 MADDU, 0x04 MSUB, 0x05 MSUBU also start a multiply.
  - At BUSY->DONE, {HI,LO} = {HI,LO} ± signed-corrected product (64-bit, wrap-around, no overflow flag).
  - Same 34-cycle latency.
- When undefined: op 0x1C is not decoded; no stall, HI/LO untouched, md_result=0.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> md_stall high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=-3 (0xFFFFFFFD) rt=7, then MFLO the next cycle -> LO=0xFFFFFFEB, HI=0xFFFFFFFF; md_result=0xFFFFFFEB in the MF's EX cycle.
- DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 then DIVU rs=5 rt=0 -> md_stall high exactly 1 cycle; HI stays 0x12345678; LO unchanged.
- Reset asserted at iteration 10 of a DIVU -> next cycle state IDLE, md_stall=0, HI=LO=0. Holding the DIVU in EX after reset restarts it from scratch.
- MULTDIV_MADD build: HI/LO=0:10, MADD rs=3 rt=4 -> LO=22. MSUBU rs=1 rt=30 -> {HI,LO}=0xFFFFFFFF_FFFFFFF8. Non-MADD build: op 0x1C leaves HI/LO unchanged, no stall.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit for the EX stage; owns HI/LO and stalls the front of the pipe.
// Optional MADD/MADDU/MSUB/MSUBU (op 0x1C) support is enabled by defining MULDIV_MADD_EN.
module ex_muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [5:0]      ex_op,
    input  logic [5:0]      ex_funct,
    input  logic [XLEN-1:0] ex_reg_data1,
    input  logic [XLEN-1:0] ex_reg_data2,
    output logic            md_stall,
    output logic [XLEN-1:0] md_result,
    output logic [XLEN-1:0] md_hi,
    output logic [XLEN-1:0] md_lo
);

    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     p_q, p_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic              acc_q, acc_d, sub_q, sub_d;

    logic is_r, f_mult, f_multu, f_div, f_divu, f_mfhi, f_mflo, f_mthi, f_mtlo;
    logic f_madd, f_maddu, f_msub, f_msubu;
    logic mul_start, div_start, signed_op, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // Instruction decode
    always_comb begin
        is_r    = (ex_op == 6'h00);
        f_mult  = is_r && (ex_funct == 6'h18);
        f_multu = is_r && (ex_funct == 6'h19);
        f_div   = is_r && (ex_funct == 6'h1A);
        f_divu  = is_r && (ex_funct == 6'h1B);
        f_mfhi  = is_r && (ex_funct == 6'h10);
        f_mflo  = is_r && (ex_funct == 6'h12);
        f_mthi  = is_r && (ex_funct == 6'h11);
        f_mtlo  = is_r && (ex_funct == 6'h13);
`ifdef MULDIV_MADD_EN
        f_madd  = (ex_op == 6'h1C) && (ex_funct == 6'h00);
        f_maddu = (ex_op == 6'h1C) && (ex_funct == 6'h01);
        f_msub  = (ex_op == 6'h1C) && (ex_funct == 6'h04);
        f_msubu = (ex_op == 6'h1C) && (ex_funct == 6'h05);
`else
        f_madd  = 1'b0;
        f_maddu = 1'b0;
        f_msub  = 1'b0;
        f_msubu = 1'b0;
`endif
        mul_start = f_mult | f_multu | f_madd | f_maddu | f_msub | f_msubu;
        div_start = f_div | f_divu;
        signed_op = f_mult | f_div | f_madd | f_msub;
        a_neg     = signed_op & ex_reg_data1[XLEN-1];
        b_neg     = signed_op & ex_reg_data2[XLEN-1];
        a_mag     = a_neg ? (~ex_reg_data1 + XLEN'(1)) : ex_reg_data1;
        b_mag     = b_neg ? (~ex_reg_data2 + XLEN'(1)) : ex_reg_data2;
    end

    logic [XLEN:0]   mul_sum, div_trial;
    logic [DW:0]     div_sh;
    logic [DW-1:0]   step_p, mul_res, hilo_acc;
    logic [XLEN-1:0] q_fix, r_fix;

    // One iteration step plus the sign/accumulate correction applied on the last step
    always_comb begin
        mul_sum   = {1'b0, p_q[DW-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
        div_sh    = {p_q, 1'b0};
        div_trial = div_sh[DW:XLEN] - {1'b0, b_q};
        if (!is_div_q)
            step_p = {mul_sum, p_q[XLEN-1:1]};
        else if (div_trial[XLEN])
            step_p = div_sh[DW-1:0];
        else
            step_p = {div_trial[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
        mul_res  = neg_q ? (~step_p + DW'(1)) : step_p;
        hilo_acc = sub_q ? ({hi_q, lo_q} - mul_res) : ({hi_q, lo_q} + mul_res);
        q_fix    = neg_q  ? (~step_p[XLEN-1:0] + XLEN'(1))  : step_p[XLEN-1:0];
        r_fix    = rneg_q ? (~step_p[DW-1:XLEN] + XLEN'(1)) : step_p[DW-1:XLEN];
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        sub_d    = sub_q;
        case (state_q)
            S_IDLE: begin
                if (div_start && (ex_reg_data2 == '0)) begin
                    state_d = S_DONE;
                end else if (mul_start || div_start) begin
                    state_d  = S_BUSY;
                    cnt_d    = '0;
                    p_d      = {XLEN'(0), a_mag};
                    b_d      = b_mag;
                    is_div_d = div_start;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    acc_d    = f_madd | f_maddu | f_msub | f_msubu;
                    sub_d    = f_msub | f_msubu;
                end else if (f_mthi) begin
                    hi_d = ex_reg_data1;
                end else if (f_mtlo) begin
                    lo_d = ex_reg_data1;
                end
            end
            S_BUSY: begin
                p_d = step_p;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end else if (acc_q) begin
                        hi_d = hilo_acc[DW-1:XLEN];
                        lo_d = hilo_acc[XLEN-1:0];
                    end else begin
                        hi_d = mul_res[DW-1:XLEN];
                        lo_d = mul_res[XLEN-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            sub_q    <= sub_d;
        end
    end

    // Stall covers the launch cycle and every iteration; DONE lets the instruction leave EX
    assign md_stall  = !reset && ((state_q == S_BUSY) ||
                       ((state_q == S_IDLE) && (mul_start || div_start)));
    assign md_result = f_mfhi ? hi_q : (f_mflo ? lo_q : '0);
    assign md_hi     = hi_q;
    assign md_lo     = lo_q;

endmodule
